// File: rtl/hallway_scheduler_if.sv
// hallway_scheduler_if
// Bundles the scheduler's handshake and data signals.
//   enable, frame_tick, step : timing/random source -> scheduler
//   drawer_done              : column drawer -> scheduler (1 = idle/finished)
//   drawer_start             : scheduler -> drawer, one-cycle start pulse
//   column, upper_pos,
//   lower_pos                : scheduler -> drawer, held stable for the whole draw
//   busy, frame_count,
//   overrun                  : scheduler status
// The slave modport is the scheduler's view. The master modport is the
// environment's view: it stands in for both the game-level source and the drawer.
interface hallway_scheduler_if;
  logic        enable;
  logic        frame_tick;
  logic [1:0]  step;
  logic        drawer_done;
  logic        drawer_start;
  logic [7:0]  column;
  logic [6:0]  upper_pos;
  logic [6:0]  lower_pos;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  overrun;

  modport slave (
    input  enable, frame_tick, step, drawer_done,
    output drawer_start, column, upper_pos, lower_pos, busy, frame_count, overrun
  );

  modport master (
    output enable, frame_tick, step, drawer_done,
    input  drawer_start, column, upper_pos, lower_pos, busy, frame_count, overrun
  );
endinterface

// File: rtl/hallway_scheduler.sv
// hallway_scheduler
// Frame-rate controller for the hallway column drawer. On each accepted frame
// tick it moves the hallway walls by one step and selects the next column. It
// then pulses drawer_start and waits for the drawer's done handshake
// (done falls, then rises).
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : hallway_scheduler_if.slave (see interface file for signal roles)
module hallway_scheduler #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int GAP      = 40,
  parameter int TOP_MIN  = 4,
  parameter int TOP_INIT = 40
) (
  input  logic               clock,
  input  logic               reset,
  hallway_scheduler_if.slave bus
);

  localparam logic [6:0] TOP_MIN_V  = 7'(TOP_MIN);
  localparam logic [6:0] TOP_MAX_V  = 7'(SCREEN_H - 1 - TOP_MIN - GAP);
  localparam logic [6:0] TOP_INIT_V = 7'(TOP_INIT);
  localparam logic [6:0] GAP_V      = 7'(GAP);
  localparam logic [7:0] COL_LAST   = 8'(SCREEN_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UPDATE    = 3'd1,
    ISSUE     = 3'd2,
    WAIT_LOW  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t      state, state_next;
  logic        pending, pending_next;
  logic        consume;
  logic        tick_ok;
  logic        first_done;
  logic [7:0]  overrun, overrun_next;
  logic [6:0]  upper, lower, upper_step;
  logic [7:0]  column, col_step;
  logic        drawer_start;
  logic        busy;
  logic [15:0] frame_count;

  assign tick_ok = bus.frame_tick & bus.enable;

  // Next-state logic; IDLE only hands off when the drawer is idle.
  always_comb begin
    state_next = state;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        if (pending && bus.drawer_done) begin
          state_next = UPDATE;
          consume    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      UPDATE:   state_next = ISSUE;
      ISSUE:    state_next = WAIT_LOW;
      WAIT_LOW: begin
        if (!bus.drawer_done) state_next = WAIT_DONE;
        else                  state_next = WAIT_LOW;
      end
      WAIT_DONE: begin
        if (bus.drawer_done) state_next = IDLE;
        else                 state_next = WAIT_DONE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // One-deep tick queue. A tick landing in the consume cycle re-arms it; any
  // other tick seen while already pending is dropped and counted.
  always_comb begin
    pending_next = pending;
    overrun_next = overrun;
    if (tick_ok) begin
      pending_next = 1'b1;
      if (pending && !consume && (overrun != 8'hFF)) overrun_next = overrun + 8'd1;
      else                                           overrun_next = overrun;
    end else if (consume) begin
      pending_next = 1'b0;
    end else begin
      pending_next = pending;
    end
  end

  // Wall step with clamping: a step that would leave the range holds the value.
  always_comb begin
    upper_step = upper;
    case (bus.step)
      2'b01: begin
        if (upper > TOP_MIN_V) upper_step = upper - 7'd1;
        else                   upper_step = upper;
      end
      2'b10: begin
        if (upper < TOP_MAX_V) upper_step = upper + 7'd1;
        else                   upper_step = upper;
      end
      default: upper_step = upper;
    endcase
  end

  // Column advance; the very first draw after reset uses column 0 unchanged.
  always_comb begin
    col_step = column;
    if (!first_done)              col_step = column;
    else if (column == COL_LAST)  col_step = 8'd0;
    else                          col_step = column + 8'd1;
  end

  // State, queue and registered outputs. drawer_start/busy are registered from
  // state_next so they line up exactly with the ISSUE / non-IDLE states.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= 1'b0;
      overrun      <= 8'd0;
      first_done   <= 1'b0;
      upper        <= TOP_INIT_V;
      lower        <= TOP_INIT_V + GAP_V;
      column       <= 8'd0;
      drawer_start <= 1'b0;
      busy         <= 1'b0;
      frame_count  <= 16'd0;
    end else begin
      state        <= state_next;
      pending      <= pending_next;
      overrun      <= overrun_next;
      drawer_start <= (state_next == ISSUE);
      busy         <= (state_next != IDLE);
      if (state == UPDATE) begin
        upper      <= upper_step;
        lower      <= upper_step + GAP_V;
        column     <= col_step;
        first_done <= 1'b1;
      end
      if ((state == WAIT_DONE) && bus.drawer_done) frame_count <= frame_count + 16'd1;
    end
  end

  assign bus.drawer_start = drawer_start;
  assign bus.column       = column;
  assign bus.upper_pos    = upper;
  assign bus.lower_pos    = lower;
  assign bus.busy         = busy;
  assign bus.frame_count  = frame_count;
  assign bus.overrun      = overrun;

endmodule

// File: tb/tb_hallway_scheduler.sv
module tb_hallway_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hallway_scheduler_if bus ();

  hallway_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // drawer model: done falls after start, stays low draw_len cycles (or forever if stall)
  int   draw_len = 4;
  logic stall    = 1'b0;
  int   dcnt     = 0;
  always @(posedge clock) begin
    if (reset) begin
      bus.drawer_done <= 1'b1;
      dcnt            <= 0;
    end else if (bus.drawer_start) begin
      bus.drawer_done <= 1'b0;
      dcnt            <= draw_len;
    end else if (!bus.drawer_done && !stall) begin
      if (dcnt <= 1) bus.drawer_done <= 1'b1;
      else           dcnt <= dcnt - 1;
    end
  end

  // start pulse monitor
  int   start_count = 0;
  int   double_cnt  = 0;
  logic prev_start  = 1'b0;
  always @(negedge clock) begin
    if (bus.drawer_start) start_count <= start_count + 1;
    if (bus.drawer_start && prev_start) double_cnt <= double_cnt + 1;
    prev_start <= bus.drawer_start;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one tick, captures outputs at the start pulse and drains the draw
  task automatic do_draw(input logic [1:0] s, output int c, output int u,
                         output int l, output int lat);
    int n;
    @(negedge clock);
    bus.step = s;
    bus.enable = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b0;
    lat = 1;
    while (!bus.drawer_start && lat < 12) begin
      @(negedge clock);
      lat++;
    end
    if (bus.drawer_start) begin
      c = bus.column; u = bus.upper_pos; l = bus.lower_pos;
    end else begin
      c = -1; u = -1; l = -1; lat = -1;
    end
    n = 0;
    while (bus.busy && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (bus.busy) check("drain_timeout", 1, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0] step;
    int         col;
    int         up;
    int         lo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c, u, l, lat, n, exp_up, sc0;

    vecs[0] = '{2'b00, 1, 40, 80};
    vecs[1] = '{2'b01, 2, 39, 79};
    vecs[2] = '{2'b01, 3, 38, 78};
    vecs[3] = '{2'b10, 4, 39, 79};
    vecs[4] = '{2'b11, 5, 39, 79};
    vecs[5] = '{2'b10, 6, 40, 80};

    bus.enable = 1'b1;
    bus.frame_tick = 1'b0;
    bus.step = 2'b00;
    repeat (3) @(negedge clock);

    // reset state (reset still asserted)
    check("rst_start", bus.drawer_start, 0);
    check("rst_column", bus.column, 0);
    check("rst_upper", bus.upper_pos, 40);
    check("rst_lower", bus.lower_pos, 80);
    check("rst_busy", bus.busy, 0);
    check("rst_fcount", bus.frame_count, 0);
    check("rst_overrun", bus.overrun, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // single tick with a long drawer
    draw_len = 120;
    do_draw(2'b00, c, u, l, lat);
    check("first_latency", lat, 3);
    check("first_column", c, 0);
    check("first_upper", u, 40);
    check("first_lower", l, 80);
    check("first_fcount", bus.frame_count, 1);
    check("first_busy", bus.busy, 0);
    check("first_starts", start_count, 1);

    // table of steps
    draw_len = 4;
    for (int i = 0; i < 6; i++) begin
      do_draw(vecs[i].step, c, u, l, lat);
      check($sformatf("vec%0d_col", i), c, vecs[i].col);
      check($sformatf("vec%0d_up", i), u, vecs[i].up);
      check($sformatf("vec%0d_lo", i), l, vecs[i].lo);
      check($sformatf("vec%0d_lat", i), lat, 3);
    end

    // column wrap: 161 draws from reset
    pulse_reset();
    for (int i = 0; i < 161; i++) begin
      do_draw(2'b00, c, u, l, lat);
      check($sformatf("wrap%0d_col", i), c, i % 160);
    end
    check("wrap_fcount", bus.frame_count, 161);
    check("wrap_upper", bus.upper_pos, 40);

    // clamp at top then bottom
    exp_up = 40;
    for (int i = 0; i < 50; i++) begin
      do_draw(2'b01, c, u, l, lat);
      exp_up = (exp_up > 4) ? exp_up - 1 : exp_up;
      check($sformatf("up%0d", i), u, exp_up);
    end
    check("top_upper", bus.upper_pos, 4);
    check("top_lower", bus.lower_pos, 44);
    for (int i = 0; i < 100; i++) begin
      do_draw(2'b10, c, u, l, lat);
      exp_up = (exp_up < 75) ? exp_up + 1 : exp_up;
      check($sformatf("down%0d", i), u, exp_up);
    end
    check("bot_upper", bus.upper_pos, 75);
    check("bot_lower", bus.lower_pos, 115);

    // enable=0 drops ticks and leaves nothing pending
    sc0 = start_count;
    @(negedge clock);
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.frame_tick = 1'b1;
      @(negedge clock);
      bus.frame_tick = 1'b0;
      @(negedge clock);
    end
    repeat (10) @(negedge clock);
    check("dis_starts", start_count, sc0);
    check("dis_busy", bus.busy, 0);
    bus.enable = 1'b1;
    repeat (10) @(negedge clock);
    check("dis_nopending", start_count, sc0);

    // tick then immediate pause still draws
    bus.frame_tick = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b0;
    bus.enable = 1'b0;
    n = 0;
    while (start_count == sc0 && n < 12) begin
      @(negedge clock);
      n++;
    end
    check("pause_draws", start_count, sc0 + 1);
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    bus.enable = 1'b1;

    // overrun: two ticks during a draw -> one dropped, next draw follows at once
    pulse_reset();
    draw_len = 20;
    @(negedge clock);
    bus.step = 2'b10;
    bus.frame_tick = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b0;
    n = 0;
    while (!bus.drawer_start && n < 12) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      bus.frame_tick = 1'b1;
      @(negedge clock);
      bus.frame_tick = 1'b0;
      @(negedge clock);
    end
    check("ovr_count", bus.overrun, 1);
    n = 0;
    while (bus.frame_count != 16'd1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("ovr_fc1", bus.frame_count, 1);
    n = 0;
    while (!bus.drawer_start && n < 12) begin
      @(negedge clock);
      n++;
    end
    check("ovr_b2b_gap", n, 2);
    check("ovr_col", bus.column, 1);
    check("ovr_upper", bus.upper_pos, 42);
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("ovr_fc2", bus.frame_count, 2);

    // stalled draw: overrun saturates
    stall = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b0;
    repeat (6) @(negedge clock);
    for (int i = 0; i < 300; i++) begin
      bus.frame_tick = 1'b1;
      @(negedge clock);
      bus.frame_tick = 1'b0;
      @(negedge clock);
    end
    check("sat_overrun", bus.overrun, 255);
    check("sat_busy", bus.busy, 1);
    check("sat_col", bus.column, 2);

    // reset while waiting for done: outputs clear at once
    reset = 1'b1;
    #1;
    check("mid_rst_col", bus.column, 0);
    check("mid_rst_upper", bus.upper_pos, 40);
    check("mid_rst_lower", bus.lower_pos, 80);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_fc", bus.frame_count, 0);
    check("mid_rst_ovr", bus.overrun, 0);
    @(negedge clock);
    stall = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    draw_len = 4;
    do_draw(2'b00, c, u, l, lat);
    check("post_rst_col", c, 0);
    check("post_rst_upper", u, 40);
    check("post_rst_lat", lat, 3);
    check("post_rst_fc", bus.frame_count, 1);

    check("start_single_cycle", double_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
